// File: rtl/regfile_ctx.sv
// regfile_ctx: pointer-indirect register file with a shadow bank and a
// sequential context save/restore engine that copies one register per cycle.
//
// The pointer register PTR_IDX holds two operand fields: A = [2D-1:D] and
// B = [D-1:0]. The flag register FLAG_IDX holds the ALU overflow bit in bit 0.
// While the copy engine is busy, architectural writes are dropped and new
// context requests are ignored. Reads stay live the whole time.
//
// Optional feature: define REGFILE_BYPASS_EN to forward the value of this
// cycle's accepted write onto DataOutA, DataOutB and MemWriteValue whenever
// that write targets the address being read. Pointer decode always uses the
// registered pointer.
module regfile_ctx #(
  parameter int W        = 8,
  parameter int D        = 4,
  parameter int PTR_IDX  = 13,
  parameter int FLAG_IDX = 12
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         WrEn,
  input  logic [D-1:0] Waddr,
  input  logic         IndWrA,
  input  logic         IndWrB,
  input  logic         PtrWrite,
  input  logic         PtrHigh,
  input  logic         FlagWe,
  input  logic         OverFlow,
  input  logic [W-1:0] DataIn,
  input  logic         Jmp,
  input  logic [D-1:0] JmpReg,
  input  logic         CtxSave,
  input  logic         CtxRestore,
  output logic         CtxBusy,
  output logic         CtxDone,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  output logic [W-1:0] MemWriteValue
);

  localparam int             NREG      = 2 ** D;
  localparam logic [D-1:0]   PTR_ADDR  = D'(PTR_IDX);
  localparam logic [D-1:0]   FLAG_ADDR = D'(FLAG_IDX);
  localparam logic [D-1:0]   CNT_LAST  = D'(NREG - 1);
  localparam logic [D-1:0]   CNT_ONE   = D'(1);

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE
  } state_e;

  state_e       state_q;
  logic [D-1:0] cnt_q;
  logic         busy_q;
  logic         done_q;

  logic [W-1:0] reg_q    [NREG];
  logic [W-1:0] reg_d    [NREG];
  logic [W-1:0] shadow_q [NREG];
  logic [W-1:0] shadow_d [NREG];
  logic [W-1:0] rd_view  [NREG];

  logic         idle;
  logic [D-1:0] ptr_a;
  logic [D-1:0] ptr_b;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic [W-1:0] ptr_new;
  logic         flag_en;
  logic [W-1:0] flag_val;

  assign idle     = (state_q == IDLE);
  assign ptr_a    = reg_q[PTR_ADDR][2*D-1:D];
  assign ptr_b    = reg_q[PTR_ADDR][D-1:0];
  assign flag_en  = idle && FlagWe;
  assign flag_val = {{(W-1){1'b0}}, OverFlow};

  // Select the single winning architectural write: IndWrA > IndWrB > PtrWrite > WrEn.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = DataIn;
    ptr_new = reg_q[PTR_ADDR];
    if (PtrHigh) ptr_new[2*D-1:D] = DataIn[D-1:0];
    else         ptr_new[D-1:0]   = DataIn[D-1:0];

    if (idle) begin
      if (IndWrA) begin
        wr_en   = 1'b1;
        wr_addr = ptr_a;
      end else if (IndWrB) begin
        wr_en   = 1'b1;
        wr_addr = ptr_b;
      end else if (PtrWrite) begin
        wr_en   = 1'b1;
        wr_addr = PTR_ADDR;
        wr_data = ptr_new;
      end else if (WrEn) begin
        wr_en   = 1'b1;
        wr_addr = Waddr;
      end
    end
  end

  // Next contents of both banks: copy engine when busy, architectural writes when idle.
  always_comb begin
    reg_d    = reg_q;
    shadow_d = shadow_q;
    case (state_q)
      SAVE:    shadow_d[cnt_q] = reg_q[cnt_q];
      RESTORE: reg_d[cnt_q]    = shadow_q[cnt_q];
      default: begin
        // The flag write goes first so a same-cycle data write to FLAG_IDX overrides it.
        if (flag_en) reg_d[FLAG_ADDR] = flag_val;
        if (wr_en)   reg_d[wr_addr]   = wr_data;
      end
    endcase
  end

  // Read view: registered contents, optionally with this cycle's accepted write forwarded.
  always_comb begin
    rd_view = reg_q;
`ifdef REGFILE_BYPASS_EN
    if (flag_en) rd_view[FLAG_ADDR] = flag_val;
    if (wr_en)   rd_view[wr_addr]   = wr_data;
`endif
  end

  assign DataOutA      = Jmp ? rd_view[JmpReg]   : rd_view[ptr_a];
  assign DataOutB      = Jmp ? rd_view[PTR_ADDR] : rd_view[ptr_b];
  assign MemWriteValue = rd_view[ptr_a];
  assign CtxBusy       = busy_q;
  assign CtxDone       = done_q;

  // Register and shadow banks; both clear on reset so a restore never returns stale data.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      // NOTE: the banks are reset explicitly because the reset contents are architecturally visible.
      for (int i = 0; i < NREG; i++) begin
        reg_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      reg_q    <= reg_d;
      shadow_q <= shadow_d;
    end
  end

  // Copy engine FSM: walks cnt over all registers, then pulses CtxDone in the first idle cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (CtxSave) begin
            state_q <= SAVE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else if (CtxRestore) begin
            state_q <= RESTORE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SAVE, RESTORE: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
